sdram_responder: RTL

- Synthesizable SDR SDRAM device responder: the chip-side end of the 16-bit SDRAM pin interface our controller drives.
- Decodes CS/RAS/CAS/WE commands, tracks the power-up sequence, the mode register and per-bank open rows, and serves reads and writes from on-chip block RAM.
- Used in simulation and FPGA loopback builds to exercise the controller without external SDRAM; also flags protocol violations.

---
 rtl/sdram_responder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_responder.sv
// Chip-side SDR SDRAM model: decodes controller commands, tracks init, mode and
// open rows, serves BL1/BL2 bursts at CAS latency 2 or 3 from on-chip RAM.
module sdram_responder #(
   parameter int MEM_AW  = 12,
   parameter int REF_MAX = 400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SDRAM_CKE,
   input  logic        SDRAM_CS_N,
   input  logic        SDRAM_RAS_N,
   input  logic        SDRAM_CAS_N,
   input  logic        SDRAM_WE_N,
   input  logic [12:0] SDRAM_A,
   input  logic [1:0]  SDRAM_BA,
   input  logic        SDRAM_DQML,
   input  logic        SDRAM_DQMH,
   input  logic [15:0] dq_i,
   output logic [15:0] dq_o,
   output logic        dq_oe,
   output logic        init_done,
   output logic        err,
   output logic [2:0]  err_code,
   output logic [15:0] refresh_count
);
   localparam int RW = $clog2(REF_MAX + 1);

   typedef enum logic [1:0] {WAIT_PRE, REFRESHING, READY} init_state_e;
   typedef enum logic [2:0] {C_NOP, C_PRE, C_REF, C_MRS, C_ACT, C_RD, C_WR, C_BST} cmd_e;

   init_state_e       state_q, state_d;
   logic [3:0]        ref_init_q, ref_init_d;
   logic              bl2_q, bl2_d, cl3_q, cl3_d;
   logic [3:0]        open_q, open_d;
   logic [12:0]       row_q [4];
   logic [12:0]       row_d [4];
   logic              err_q, err_d;
   logic [2:0]        code_q, code_d;
   logic [15:0]       rcount_q, rcount_d;
   logic [RW-1:0]     rtimer_q, rtimer_d;
   logic [2:0]        new_err;
   logic              mode_ok;
   cmd_e              cmd;

   always_comb begin
      cmd = C_NOP;
      if (SDRAM_CKE && !SDRAM_CS_N) begin
         case ({SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N})
            3'b010:  cmd = C_PRE;
            3'b001:  cmd = C_REF;
            3'b000:  cmd = C_MRS;
            3'b011:  cmd = C_ACT;
            3'b101:  cmd = C_RD;
            3'b100:  cmd = C_WR;
            3'b110:  cmd = C_BST;
            default: cmd = C_NOP;
         endcase
      end
   end

   assign mode_ok = (SDRAM_A[2:1] == 2'b00) && (SDRAM_A[6:5] == 2'b01);

   always_comb begin
      state_d    = state_q;
      ref_init_d = ref_init_q;
      bl2_d      = bl2_q;
      cl3_d      = cl3_q;
      open_d     = open_q;
      row_d      = row_q;
      err_d      = err_q;
      code_d     = code_q;
      rcount_d   = rcount_q;
      rtimer_d   = rtimer_q;
      new_err    = 3'd0;
      case (cmd)
         C_PRE: begin
            if (SDRAM_A[10]) open_d = 4'b0000;
            else             open_d[SDRAM_BA] = 1'b0;
            if (state_q == WAIT_PRE && SDRAM_A[10]) state_d = REFRESHING;
         end
         C_REF: begin
            rcount_d = rcount_q + 16'd1;
            if (|open_q) new_err = 3'd4;
            if (state_q == REFRESHING && ref_init_q != 4'd8) ref_init_d = ref_init_q + 4'd1;
         end
         C_MRS: begin
            if (mode_ok) begin
               bl2_d = SDRAM_A[0];
               cl3_d = SDRAM_A[4];
               if (state_q == REFRESHING && ref_init_q == 4'd8) state_d = READY;
            end else begin
               new_err = 3'd5;
            end
         end
         C_ACT: begin
            if (state_q != READY) begin
               new_err = 3'd1;
            end else begin
               if (open_q[SDRAM_BA]) new_err = 3'd3;
               open_d[SDRAM_BA] = 1'b1;
               row_d[SDRAM_BA]  = SDRAM_A;
            end
         end
         C_RD, C_WR: begin
            if (state_q != READY)          new_err = 3'd1;
            else if (!open_q[SDRAM_BA])    new_err = 3'd2;
         end
         default: ;
      endcase
      // Saturating interval timer: overdue is reported once until the next refresh.
      if (cmd == C_REF) begin
         rtimer_d = '0;
      end else if (state_q == READY && rtimer_q != RW'(REF_MAX)) begin
         rtimer_d = rtimer_q + 1'b1;
         if (rtimer_d == RW'(REF_MAX) && new_err == 3'd0) new_err = 3'd6;
      end
      if (!err_q && new_err != 3'd0) begin
         err_d  = 1'b1;
         code_d = new_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT_PRE;
         ref_init_q <= 4'd0;
         bl2_q      <= 1'b0;
         cl3_q      <= 1'b0;
         open_q     <= 4'b0000;
         for (int i = 0; i < 4; i++) row_q[i] <= 13'd0;
         err_q      <= 1'b0;
         code_q     <= 3'd0;
         rcount_q   <= 16'd0;
         rtimer_q   <= '0;
      end else begin
         state_q    <= state_d;
         ref_init_q <= ref_init_d;
         bl2_q      <= bl2_d;
         cl3_q      <= cl3_d;
         open_q     <= open_d;
         row_q      <= row_d;
         err_q      <= err_d;
         code_q     <= code_d;
         rcount_q   <= rcount_d;
         rtimer_q   <= rtimer_d;
      end
   end

   logic [22:0]       full_addr;
   logic [MEM_AW-1:0] cmd_idx, bst_idx_q, wr_idx, rd_idx;
   logic              rd_go, wr_go, cancel, wr_en, rd_issue;
   logic              bst_v_q, bst_rd_q, dqm_all_q;
   logic [2:0]        pv_q;
   logic [MEM_AW-1:0] pidx_q [2];
   logic [15:0]       dq_q;
   logic [15:0]       mem [2**MEM_AW];
   logic [22:0]       unused_addr;

   assign full_addr   = {SDRAM_BA, row_q[SDRAM_BA], SDRAM_A[7:0]};
   assign cmd_idx     = full_addr[MEM_AW-1:0];
   assign unused_addr = full_addr;
   assign rd_go    = (cmd == C_RD) && (state_q == READY) && open_q[SDRAM_BA];
   assign wr_go    = (cmd == C_WR) && (state_q == READY) && open_q[SDRAM_BA];
   assign cancel   = (cmd == C_RD) || (cmd == C_WR) || (cmd == C_BST);
   assign wr_en    = SDRAM_CKE && (wr_go || (bst_v_q && !bst_rd_q && !cancel));
   assign wr_idx   = wr_go ? cmd_idx : bst_idx_q;
   assign rd_issue = SDRAM_CKE && (rd_go || (bst_v_q && bst_rd_q && !cancel));
   assign rd_idx   = rd_go ? cmd_idx : bst_idx_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (!SDRAM_DQML) mem[wr_idx][7:0]  <= dq_i[7:0];
         if (!SDRAM_DQMH) mem[wr_idx][15:8] <= dq_i[15:8];
      end
   end

   // CL3 issues into stage 0, CL2 straight into stage 1; stage 1 feeds the RAM
   // read register and stage 2 marks the word currently on dq_o.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bst_v_q   <= 1'b0;
         bst_rd_q  <= 1'b0;
         bst_idx_q <= '0;
         dqm_all_q <= 1'b0;
         pv_q      <= 3'b000;
         pidx_q[0] <= '0;
         pidx_q[1] <= '0;
         dq_q      <= 16'd0;
      end else if (SDRAM_CKE) begin
         if (cancel) begin
            bst_v_q   <= bl2_q && (rd_go || wr_go);
            bst_rd_q  <= rd_go;
            bst_idx_q <= cmd_idx ^ MEM_AW'(1);
         end else begin
            bst_v_q   <= 1'b0;
         end
         dqm_all_q <= SDRAM_DQML && SDRAM_DQMH;
         pv_q[0]   <= rd_issue && cl3_q;
         pidx_q[0] <= rd_idx;
         pv_q[1]   <= (rd_issue && !cl3_q) || (pv_q[0] && !cancel);
         pidx_q[1] <= (rd_issue && !cl3_q) ? rd_idx : pidx_q[0];
         pv_q[2]   <= pv_q[1] && !dqm_all_q && !cancel;
         if (pv_q[1]) dq_q <= mem[pidx_q[1]];
      end
   end

   assign dq_o          = dq_q;
   assign dq_oe         = pv_q[2];
   assign init_done     = (state_q == READY);
   assign err           = err_q;
   assign err_code      = code_q;
   assign refresh_count = rcount_q;
endmodule
